// File: rtl/box_hit_detector.sv
// Box hit detector: 2-flop synchronizer, debounce filter, hit event FSM and a
// first-word fall-through event FIFO. Define HIT_RELEASE_EVENT_EN to also emit box-0 release events.
module box_hit_detector #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] box_address,
  output logic       hit_valid,
  input  logic       hit_ready,
  output logic [2:0] hit_box,
  output logic [7:0] hit_count,
  output logic [3:0] fifo_level,
  output logic       overflow
);

  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       LEVEL_FULL = 4'(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [2:0]       sync_meta, sync_addr;
  logic [2:0]       candidate, stable_addr;
  logic [CNT_W-1:0] deb_cnt;
  logic [0:0]       state, state_next;
  logic             settle;

  logic             push, pop, full, accept, drop;
  logic [2:0]       push_data, head_next;
  logic [3:0]       level_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [2:0]       mem [FIFO_DEPTH];

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_addr <= '0;
    end else begin
      sync_meta <= box_address;
      sync_addr <= sync_meta;
    end
  end

  assign settle = (deb_cnt == CNT_MAX) && (candidate != stable_addr);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      candidate   <= '0;
      deb_cnt     <= '0;
      stable_addr <= '0;
    end else begin
      if (sync_addr != candidate) begin
        candidate <= sync_addr;
        deb_cnt   <= '0;
      end else if (deb_cnt != CNT_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (settle) stable_addr <= candidate;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push       = 1'b0;
    push_data  = candidate;
    state_next = state;
    if (settle) begin
      if (candidate != 3'd0) begin
        push       = 1'b1;
        state_next = HELD;
      end else begin
        state_next = IDLE;
`ifdef HIT_RELEASE_EVENT_EN
        push       = (state == HELD);
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign pop        = hit_valid & hit_ready;
  assign full       = (fifo_level == LEVEL_FULL);
  assign accept     = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign level_next = fifo_level + 4'(accept) - 4'(pop);
  assign rd_next    = rd_ptr + PTR_W'(pop);

  // Next head comes straight from the push when the FIFO would otherwise be empty.
  always_comb begin
    head_next = 3'd0;
    if (level_next != 4'd0) begin
      if (fifo_level == 4'd0 || (pop && fifo_level == 4'd1)) head_next = push_data;
      else                                                   head_next = mem[rd_next];
    end
  end

  // NOTE: storage is not reset; pointers and level alone decide what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hit_valid  <= 1'b0;
      hit_box    <= '0;
      hit_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(accept);
      rd_ptr     <= rd_next;
      fifo_level <= level_next;
      hit_valid  <= (level_next != 4'd0);
      hit_box    <= head_next;
      hit_count  <= hit_count + 8'(accept);
      overflow   <= overflow | drop;
    end
  end

endmodule

// File: doc/box_hit_detector.md
Name: box_hit_detector

Overview:
- Sits directly downstream of the sensor-read stage and consumes its raw 3-bit box_address from the GPIO sensor lines.
- Synchronizes and debounces the address, then turns each settled new hit into one event.
- Buffers events in a small FIFO with a valid/ready handshake, so game logic can take hits one at a time without missing any.
- Box value 0 means "no box hit".

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive clocks a synchronized value must hold before it is accepted (1 ms at 50 MHz); legal range 2..65535
FIFO_DEPTH, 4, event FIFO entries; power of two, 2..8
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
CLOCK_50  input  1  system clock
reset  input  1  asynchronous, active-high reset
box_address  input  3  raw box number from the sensor-read stage, asynchronous to CLOCK_50
hit_valid  output  1  FIFO head holds an event
hit_ready  input  1  consumer accepts the head this cycle
hit_box  output  3  box number of the FIFO head; 0 when empty
hit_count  output  8  number of events pushed since reset; wraps 255->0
fifo_level  output  4  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky; set when an event was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high) clears the following, effective immediately and not waiting for a clock edge:
  - all outputs: hit_valid=0, hit_box=0, hit_count=0, fifo_level=0, overflow=0;
  - synchronizer, candidate, stable value, debounce counter, FSM (to IDLE) and FIFO pointers.
- Synchronizer: two flops on all 3 bits; sync_addr lags box_address by 2 edges.
- Debounce filter:
  - When sync_addr != candidate: candidate<=sync_addr and counter<=0.
  - Otherwise counter increments, saturating at DEBOUNCE_CYCLES-1.
  - When counter==DEBOUNCE_CYCLES-1 and candidate != stable: stable<=candidate (one-cycle "settle" strobe).
- Event FSM, states IDLE (stable==0) and HELD (stable!=0):
  - IDLE, settle to nonzero v: push v, go to HELD.
  - HELD, settle to a different nonzero v: push v, stay in HELD.
  - HELD, settle to 0: no push, go to IDLE.
  - Re-settling to the same value never pushes.
- Latency: with box_address stable from edge 0, hit_valid rises after edge DEBOUNCE_CYCLES+3 (FIFO empty); hit_box is valid in the same cycle.
- FIFO:
  - Push when the FSM emits an event.
  - Pop on hit_valid & hit_ready.
  - hit_valid = (fifo_level!=0), hit_box = head entry; both registered, with no combinational path from hit_ready.
  - First-word fall-through: the head is visible the cycle after the push.
- Boundary conditions:
  - Push while full with no pop: event dropped, overflow<=1 (cleared only by reset), hit_count unchanged.
  - Push and pop in the same cycle while full: both happen, level stays FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle while empty: impossible, since hit_valid=0.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - hit_count increments only on accepted pushes and wraps 255->0.
  - Reset during debounce or with a non-empty FIFO discards everything. An address still held after reset is treated as a new hit once it settles again.

Optional Feature:
- Macro: HIT_RELEASE_EVENT_EN.
- Defined: the HELD->IDLE transition also pushes an event with hit_box=0 (release). Release events count in hit_count and obey the overflow rules.
- Undefined: releases produce no event, and the FIFO never holds 0.

Test Plan:
- Assert reset with FIFO non-empty, no clock running -> hit_valid=0, hit_box=0, fifo_level=0, hit_count=0, overflow=0 immediately.
- DEBOUNCE_CYCLES=4, hit_ready=1, box_address 0->5 held 20 cycles -> hit_valid high exactly one cycle, after edge 7, hit_box=5, hit_count=1.
- DEBOUNCE_CYCLES=4, box_address=2 for 3 cycles then 0 -> no event, hit_count=0.
- hit_ready=0, hits 1,2,3,4,5 each separated by settled 0 -> fifo_level=4, overflow=1, hit_count=4. Then hit_ready=1 -> pops 1,2,3,4 on consecutive cycles, then hit_valid=0.
- box_address 3 held to settle, then directly 6 -> two events 3 then 6. With HIT_RELEASE_EVENT_EN, a following return to 0 adds an event with hit_box=0.
- FIFO full, a new settle coincides with hit_ready=1 -> level stays 4, overflow stays 0, the new box appears as the tail entry.
